// File: rtl/key_control_pkg.sv
// Shared constants and helpers for the key_control push-button front end.
// Holds debounce sizing, rate-select encodings and the rate step function.
package key_control_pkg;

    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNT_W             = 20;
    localparam int NUM_KEYS          = 3;

    localparam int KEY_SPEED = 0;
    localparam int KEY_RUN   = 1;
    localparam int KEY_LOAD  = 2;

    // Rate-select encodings understood by the downstream rate divider.
    typedef enum logic [1:0] {
        FREQ_MAX = 2'b00,
        FREQ_1S  = 2'b01,
        FREQ_2S  = 2'b10,
        FREQ_4S  = 2'b11
    } freq_e;

    localparam freq_e FREQ_RST = FREQ_1S;

    function automatic freq_e freq_step(input freq_e cur);
        case (cur)
            FREQ_1S:  return FREQ_2S;
            FREQ_2S:  return FREQ_4S;
            FREQ_4S:  return FREQ_MAX;
            FREQ_MAX: return FREQ_1S;
            default:  return FREQ_RST;
        endcase
    endfunction

endpackage

// File: rtl/key_control_if.sv
// Button/switch inputs and rate-divider/counter control outputs of key_control.
interface key_control_if;

    logic [2:0] key_n;
    logic [3:0] sw_value;
    logic [1:0] frequency;
    logic       enable;
    logic       par_load;
    logic [3:0] load;

    modport master (
        output key_n,
        output sw_value,
        input  frequency,
        input  enable,
        input  par_load,
        input  load
    );

    modport slave (
        input  key_n,
        input  sw_value,
        output frequency,
        output enable,
        output par_load,
        output load
    );

endinterface

// File: rtl/key_control_debouncer.sv
// One push-button channel: 2-flop synchronizer, hold-time debouncer and a
// registered one-cycle press pulse on each debounced 1->0 transition.
module key_debouncer
    import key_control_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_r;
    logic             stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             press_r;

    logic             stable_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             press_next_s;

    // Debounce decision: any return to the stable level restarts the hold time.
    always_comb begin
        stable_next_s = stable_r;
        cnt_next_s    = CNT_ZERO;
        press_next_s  = 1'b0;
        if (sync_r[1] == stable_r) begin
            cnt_next_s = CNT_ZERO;
        end else if (cnt_r == CNT_LAST) begin
            stable_next_s = sync_r[1];
            cnt_next_s    = CNT_ZERO;
            press_next_s  = ~sync_r[1];
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
        end
    end

    // Synchronizer, stable level, hold counter and press pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r   <= 2'b11;
            stable_r <= 1'b1;
            cnt_r    <= CNT_ZERO;
            press_r  <= 1'b0;
        end else begin
            sync_r   <= {sync_r[0], key_n};
            stable_r <= stable_next_s;
            cnt_r    <= cnt_next_s;
            press_r  <= press_next_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/key_control.sv
// Three debounced push-buttons driving rate select, run enable and a
// parallel-load strobe/value for a downstream counter.
module key_control
    import key_control_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    key_control_if.slave  bus
);

    logic [NUM_KEYS-1:0] press_s;

    freq_e      frequency_r;
    logic       enable_r;
    logic       par_load_r;
    logic [3:0] load_r;

    freq_e      frequency_next_s;
    logic       enable_next_s;
    logic       par_load_next_s;
    logic [3:0] load_next_s;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debouncer #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debouncer (
            .clk     (clk),
            .reset_n (reset_n),
            .key_n   (bus.key_n[k]),
            .press   (press_s[k])
        );
    end

    // Each key acts on its own register so simultaneous presses all land together.
    always_comb begin
        frequency_next_s = frequency_r;
        enable_next_s    = enable_r;
        load_next_s      = load_r;
        par_load_next_s  = 1'b0;
        if (press_s[KEY_SPEED]) begin
            frequency_next_s = freq_step(frequency_r);
        end else begin
            frequency_next_s = frequency_r;
        end
        if (press_s[KEY_RUN]) begin
            enable_next_s = ~enable_r;
        end else begin
            enable_next_s = enable_r;
        end
        if (press_s[KEY_LOAD]) begin
            load_next_s     = bus.sw_value;
            par_load_next_s = 1'b1;
        end else begin
            load_next_s     = load_r;
            par_load_next_s = 1'b0;
        end
    end

    // Action registers feeding the rate divider and counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frequency_r <= FREQ_RST;
            enable_r    <= 1'b0;
            par_load_r  <= 1'b0;
            load_r      <= 4'b0000;
        end else begin
            frequency_r <= frequency_next_s;
            enable_r    <= enable_next_s;
            par_load_r  <= par_load_next_s;
            load_r      <= load_next_s;
        end
    end

    assign bus.frequency = frequency_r;
    assign bus.enable    = enable_r;
    assign bus.par_load  = par_load_r;
    assign bus.load      = load_r;

endmodule

// File: tb/tb_key_control.sv
// Directed bench for key_control with a short debounce time (latency 7 edges).
module tb_key_control;

    localparam int DB = 4;

    typedef struct packed {
        logic [2:0] mask;
        logic [3:0] sw;
        logic [1:0] freq;
        logic       en;
        logic [3:0] ld;
        logic       par;
    } vec_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    vec_t tbl [9];
    logic [9:0] prev;

    key_control_if bus();

    key_control #(.DB_CYCLES(DB)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] outs();
        return {bus.frequency, bus.enable, bus.par_load, bus.load, 2'b00};
    endfunction

    function automatic logic [9:0] pack(input logic [1:0] f, input logic e, input logic p, input logic [3:0] l);
        return {f, e, p, l, 2'b00};
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got freq=%b en=%b par=%b load=%h, expected freq=%b en=%b par=%b load=%h",
                     name, act[9:8], act[7], act[6], act[5:2], exp[9:8], exp[7], exp[6], exp[5:2]);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Press keys in v.mask, hold 20 clocks, release, let the release settle.
    task automatic run_vec(input vec_t v, input int idx);
        bus.sw_value = v.sw;
        bus.key_n    = ~v.mask;
        wait_neg(6);
        check($sformatf("vec%0d_edge6", idx), outs(), prev);
        wait_neg(1);
        check($sformatf("vec%0d_edge7", idx), outs(), pack(v.freq, v.en, v.par, v.ld));
        wait_neg(1);
        check($sformatf("vec%0d_edge8", idx), outs(), pack(v.freq, v.en, 1'b0, v.ld));
        wait_neg(12);
        bus.key_n = 3'b111;
        wait_neg(20);
        check($sformatf("vec%0d_release", idx), outs(), pack(v.freq, v.en, 1'b0, v.ld));
        prev = pack(v.freq, v.en, 1'b0, v.ld);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        tbl[0] = '{mask: 3'b001, sw: 4'h0, freq: 2'b10, en: 1'b0, ld: 4'h0, par: 1'b0};
        tbl[1] = '{mask: 3'b001, sw: 4'h0, freq: 2'b11, en: 1'b0, ld: 4'h0, par: 1'b0};
        tbl[2] = '{mask: 3'b001, sw: 4'h0, freq: 2'b00, en: 1'b0, ld: 4'h0, par: 1'b0};
        tbl[3] = '{mask: 3'b001, sw: 4'h0, freq: 2'b01, en: 1'b0, ld: 4'h0, par: 1'b0};
        tbl[4] = '{mask: 3'b001, sw: 4'h0, freq: 2'b10, en: 1'b0, ld: 4'h0, par: 1'b0};
        tbl[5] = '{mask: 3'b100, sw: 4'hA, freq: 2'b10, en: 1'b0, ld: 4'hA, par: 1'b1};
        tbl[6] = '{mask: 3'b011, sw: 4'hA, freq: 2'b11, en: 1'b1, ld: 4'hA, par: 1'b0};
        tbl[7] = '{mask: 3'b010, sw: 4'hC, freq: 2'b11, en: 1'b0, ld: 4'hA, par: 1'b0};
        tbl[8] = '{mask: 3'b100, sw: 4'h5, freq: 2'b11, en: 1'b0, ld: 4'h5, par: 1'b1};

        reset_n      = 1'b0;
        bus.key_n    = 3'b111;
        bus.sw_value = 4'h0;
        wait_neg(3);
        check("reset_values", outs(), pack(2'b01, 1'b0, 1'b0, 4'h0));
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 10 == 9) check("idle_no_event", outs(), pack(2'b01, 1'b0, 1'b0, 4'h0));
        end
        prev = pack(2'b01, 1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

        bus.sw_value = 4'h3;
        wait_neg(10);
        check("sw_change_no_load", outs(), pack(2'b11, 1'b0, 1'b0, 4'h5));

        // Reset while key[0] is two counts into its debounce.
        bus.key_n = 3'b110;
        wait_neg(4);
        #2 reset_n = 1'b0;
        #1 check("async_reset", outs(), pack(2'b01, 1'b0, 1'b0, 4'h0));
        bus.key_n = 3'b111;
        @(negedge clk);
        reset_n = 1'b1;
        wait_neg(20);
        check("no_event_after_reset", outs(), pack(2'b01, 1'b0, 1'b0, 4'h0));

        // Key held low through reset release.
        reset_n   = 1'b0;
        bus.key_n = 3'b110;
        wait_neg(3);
        reset_n = 1'b1;
        wait_neg(6);
        check("held_reset_edge6", outs(), pack(2'b01, 1'b0, 1'b0, 4'h0));
        wait_neg(1);
        check("held_reset_edge7", outs(), pack(2'b10, 1'b0, 1'b0, 4'h0));
        wait_neg(20);
        check("held_reset_once", outs(), pack(2'b10, 1'b0, 1'b0, 4'h0));
        bus.key_n = 3'b111;
        wait_neg(20);

        // Bounce on run key: low 2, high 1, then low steady.
        bus.key_n = 3'b101;
        wait_neg(2);
        bus.key_n = 3'b111;
        wait_neg(1);
        bus.key_n = 3'b101;
        wait_neg(6);
        check("bounce_edge6", outs(), pack(2'b10, 1'b0, 1'b0, 4'h0));
        wait_neg(1);
        check("bounce_edge7", outs(), pack(2'b10, 1'b1, 1'b0, 4'h0));
        wait_neg(20);
        check("bounce_once", outs(), pack(2'b10, 1'b1, 1'b0, 4'h0));
        bus.key_n = 3'b111;
        wait_neg(20);
        check("bounce_release", outs(), pack(2'b10, 1'b1, 1'b0, 4'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_control.md
KEY_CONTROL -- requirements
Module: key_control

Interface
REQ-001 Parameter: DB_CYCLES, default 1000000, debounce hold time in clocks (20 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 Port: clk  input  1  single rising-edge clock.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: key_n  input  3  raw push-buttons, active-low, asynchronous to clk; [0] speed step, [1] run toggle, [2] load.
REQ-005 Port: sw_value  input  4  parallel-load value for the downstream counter.
REQ-006 Port: frequency  output  2  rate select for the downstream rate divider.
REQ-007 Port: enable  output  1  run enable for the downstream rate divider.
REQ-008 Port: par_load  output  1  one-cycle parallel-load strobe to the downstream counter.
REQ-009 Port: load  output  4  load value, stable while par_load is high.

Function
REQ-010 Each key bit SHALL pass through its own 2-flop synchronizer before any other use.
REQ-011 Each key SHALL have a stable-state register and a 20-bit debounce counter.
REQ-012 While the synchronized value equals the stable state, the counter SHALL hold at 0.
REQ-013 While the values differ, the counter SHALL increment once per clock.
REQ-014 When the values differ and the counter equals DB_CYCLES-1, the stable state SHALL take the synchronized value and the counter SHALL return to 0 on that edge.
REQ-015 A bounce SHALL clear the counter to 0 with no stable-state change; a bounce is the synchronized value returning to the stable state before the count completes.
REQ-016 A press event SHALL be a one-cycle pulse on a stable-state 1->0 transition; a release (0->1) SHALL generate no event.
REQ-017 A key held low SHALL generate exactly one press event until released and re-pressed.
REQ-018 Speed-step press: frequency SHALL advance 01->10->11->00->01 (wrap-around).
REQ-019 Run-toggle press: enable SHALL invert.
REQ-020 Load press: load SHALL capture sw_value and par_load SHALL be high for exactly one cycle on the same edge.
REQ-021 Latency: frequency, enable, load and par_load SHALL change on the (DB_CYCLES+3)th rising edge after the first edge that samples a clean raw transition (2 sync + DB_CYCLES debounce + 1 action).
REQ-022 Press events on different keys in the same cycle SHALL all take effect on the same edge, independently.
REQ-023 sw_value changes without a load press SHALL not affect load.
REQ-024 The block SHALL generate no press event after reset if keys are idle high.

Reset
REQ-025 On reset_n low, all state SHALL clear immediately, regardless of clk.
REQ-026 Reset values SHALL be: synchronizers 1, stable states 1, counters 0, frequency 2'b01, enable 0, par_load 0, load 4'b0000.
REQ-027 A key held low across reset release SHALL debounce from the released state and produce one press event, DB_CYCLES+3 edges later.
REQ-028 Reset mid-debounce SHALL discard the count; no event SHALL be generated from pre-reset history.

Structure
REQ-029 The shared package SHALL hold the DB_CYCLES default, the counter width (20), the frequency encodings (00 max, 01 1 s, 10 2 s, 11 4 s) and the frequency reset value.
REQ-030 Sub-module key_debouncer SHALL contain one synchronizer, stable register, counter and press-pulse output.
REQ-031 key_control SHALL instance key_debouncer three times.
REQ-032 Action registers (frequency, enable, load, par_load) SHALL reside in key_control.

Verification (DB_CYCLES=4, so latency = 7 edges)
REQ-033 Reset, keys idle high -> frequency=01, enable=0, par_load=0, load=0; no change over 100 clocks.
REQ-034 key_n[0] clean press, held for 20 clocks -> frequency=10 on edge 7. Four more press/release cycles -> 11, 00, 01, 10.
REQ-035 key_n[1] bounces low 2 clocks, high 1, then low steady -> enable toggles 0->1 exactly once, 7 edges after the last falling transition.
REQ-036 sw_value=4'hA, key_n[2] pressed -> load=A and par_load=1 for one cycle on edge 7. sw_value=4'h3 without a press -> load stays A.
REQ-037 key_n[0] and key_n[1] pressed on the same edge -> frequency steps and enable toggles on the same edge 7.
REQ-038 reset_n pulsed low at debounce count 2 -> outputs at reset values immediately and no event. Then key held low through reset release -> one event 7 edges after release.
